// File: rtl/ahb_sram_ws_pkg.sv
// ahb_pkg: shared encodings for the wait-state AHB-Lite SRAM slave.
//   - AHB HTRANS / HRESP / HSIZE encodings
//   - slave FSM state encoding (also driven out on the debug state port)
//   - lane_mask(): byte-lane enables for a transfer of size HSIZE at low address bits
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_LAST = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } sram_state_e;

  // 2^size consecutive lanes starting at lane 'low', little-endian.
  // Only meaningful for legal (aligned, in-width) transfers.
  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] low);
    logic [15:0] m;
    case (size)
      HSIZE_BYTE: m = 16'h0001;
      HSIZE_HALF: m = 16'h0003;
      HSIZE_WORD: m = 16'h000F;
      default:    m = 16'h00FF;
    endcase
    m = m << low;
    return m[7:0];
  endfunction

endpackage

// File: rtl/ahb_sram_ws_mem.sv
// ahb_sram_ws_mem: byte-lane SRAM array for ahb_sram_ws.
// Ports:
//   HCLK   - clock; writes commit on the rising edge
//   we     - write strobe, be selects the byte lanes written
//   idx    - word index, shared by the write port and the combinational read
//   wdata  - write data, rdata - combinational read of word idx
//   rpar   - (AHB_SRAM_PARITY_EN only) stored even-parity bit per byte of word idx
// Contents are not reset.
module ahb_sram_ws_mem #(
  parameter int DW    = 32,
  parameter int DEPTH = 512,
  parameter int IDX_W = 9
) (
  input  logic             HCLK,
  input  logic             we,
  input  logic [DW/8-1:0]  be,
  input  logic [IDX_W-1:0] idx,
  input  logic [DW-1:0]    wdata,
`ifdef AHB_SRAM_PARITY_EN
  output logic [DW/8-1:0]  rpar,
`endif
  output logic [DW-1:0]    rdata
);

  localparam int NB = DW / 8;

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge HCLK) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[idx];

`ifdef AHB_SRAM_PARITY_EN
  // Even parity: the stored bit makes the 9-bit byte+parity group have an even count of ones.
  logic [NB-1:0] par_q [DEPTH];

  always_ff @(posedge HCLK) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) par_q[idx][i] <= ^wdata[8*i +: 8];
      end
    end
  end

  assign rpar = par_q[idx];
`endif

endmodule

// File: rtl/ahb_sram_ws.sv
// ahb_sram_ws: AHB-Lite SRAM slave with programmable wait states, HSIZE byte-lane
// writes and a two-cycle ERROR response for illegal accesses.
// Optional feature macro: AHB_SRAM_PARITY_EN (per-byte even parity, read check).
// Ports:
//   HCLK, HRESETN (async active-low)
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST (ignored), HWDATA, HREADYIN - AHB inputs
//   HRDATA, HREADYOUT, HRESP - AHB outputs
//   dbg_state - current FSM state
// Handshake: an address phase is taken when HSEL & HREADYIN & HTRANS[1]; the data
// phase ends in the first cycle with HREADYOUT=1. New address phases are only
// evaluated in IDLE, LAST and ERR2, the cycles in which this slave drives ready.
module ahb_sram_ws
  import ahb_pkg::*;
#(
  parameter int                    AHB_AWIDTH    = 32,
  parameter int                    AHB_DWIDTH    = 32,
  parameter int                    SIZE_IN_BYTES = 2048,
  parameter logic [AHB_AWIDTH-1:0] BASE_ADDR     = '0,
  parameter int                    WAIT_STATES   = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  HSEL,
  input  logic [AHB_AWIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [AHB_DWIDTH-1:0] HWDATA,
  input  logic                  HREADYIN,
  output logic [AHB_DWIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  output sram_state_e           dbg_state
);

  localparam int NB     = AHB_DWIDTH / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int DEPTH  = SIZE_IN_BYTES / NB;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] MAX_SIZE = 3'(LANE_W);
  localparam logic [2:0] WS_LOAD  = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam logic [AHB_AWIDTH-1:0] SIZE_A = AHB_AWIDTH'(SIZE_IN_BYTES);

  sram_state_e      state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             wr_q;
  logic [IDX_W-1:0] idx_q;
  logic [NB-1:0]    be_q;

  logic                  accept, illegal, load, show, par_err, ready, slot;
  logic [1:0]            resp;
  logic [AHB_AWIDTH-1:0] off;
  logic [2:0]            align, low3;
  logic [7:0]            mask8;
  logic [AHB_DWIDTH-1:0] rdata;

  logic unused_bits;
  assign unused_bits = ^{HBURST, HTRANS[0]};

  // Address-phase decode
  assign accept = HSEL & HREADYIN & HTRANS[1];
  assign off    = HADDR - BASE_ADDR;   // below-base addresses wrap large and fail the range test
  assign low3   = 3'(off[LANE_W-1:0]);
  assign mask8  = lane_mask(HSIZE, low3);

  always_comb begin
    align = 3'b111;
    case (HSIZE)
      HSIZE_BYTE: align = 3'b000;
      HSIZE_HALF: align = 3'b001;
      HSIZE_WORD: align = 3'b011;
      default:    align = 3'b111;
    endcase
  end

  assign illegal = (off >= SIZE_A) | (HSIZE > MAX_SIZE) | (|(HADDR[2:0] & align));

  // State register
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        wr_q  <= HWRITE;
        idx_q <= off[LANE_W +: IDX_W];
        be_q  <= mask8[NB-1:0];
      end
    end
  end

  // Next state and outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    ready   = 1'b1;
    resp    = HRESP_OKAY;
    show    = 1'b0;
    slot    = 1'b0;
    case (state_q)
      ST_IDLE: slot = 1'b1;
      ST_WAIT: begin
        ready = 1'b0;
        show  = 1'b1;
        if (cnt_q == 3'd0) state_d = ST_LAST;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_LAST: begin
        show = 1'b1;
        // A failed parity check turns this cycle into the first ERROR cycle;
        // the read data stays visible while the error is signalled.
        if (par_err) begin
          ready   = 1'b0;
          resp    = HRESP_ERROR;
          state_d = ST_ERR2;
        end else begin
          slot = 1'b1;
        end
      end
      ST_ERR1: begin
        ready   = 1'b0;
        resp    = HRESP_ERROR;
        state_d = ST_ERR2;
      end
      ST_ERR2: begin
        resp = HRESP_ERROR;
        slot = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Completing cycles double as address-phase slots for back-to-back transfers.
    if (slot) begin
      state_d = ST_IDLE;
      if (accept) begin
        load = 1'b1;
        if (illegal) begin
          state_d = ST_ERR1;
        end else if (WAIT_STATES > 0) begin
          state_d = ST_WAIT;
          cnt_d   = WS_LOAD;
        end else begin
          state_d = ST_LAST;
        end
      end
    end
  end

  ahb_sram_ws_mem #(
    .DW    (AHB_DWIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .HCLK  (HCLK),
    .we    ((state_q == ST_LAST) & wr_q),
    .be    (be_q),
    .idx   (idx_q),
    .wdata (HWDATA),
`ifdef AHB_SRAM_PARITY_EN
    .rpar  (rpar),
`endif
    .rdata (rdata)
  );

`ifdef AHB_SRAM_PARITY_EN
  logic [NB-1:0] rpar, calc;
  always_comb begin
    calc = '0;
    for (int i = 0; i < NB; i++) calc[i] = ^rdata[8*i +: 8];
  end
  assign par_err = ~wr_q & (|(be_q & (rpar ^ calc)));
`else
  assign par_err = 1'b0;
`endif

  assign HREADYOUT = ready;
  assign HRESP     = resp;
  assign HRDATA    = show ? rdata : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_sram_ws.sv
// Bench: two ahb_sram_ws slaves on one AHB-Lite bus.
//   slave 0: WAIT_STATES=0, base 0x0000; slave 1: WAIT_STATES=3, base 0x1000.
// Directed scenarios followed by random transfers checked against a byte-array model.
module tb_ahb_sram_ws;
  import ahb_pkg::*;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_1000;

  // Clock / reset
  logic HCLK = 1'b0;
  logic HRESETN = 1'b0;
  always #5 HCLK = ~HCLK;

  // Bus
  logic        HSEL0 = 1'b0, HSEL1 = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd0;
  logic [2:0]  HBURST = 3'd0;
  logic [31:0] HWDATA = '0;
  logic [31:0] rdata0, rdata1;
  logic        rdy0, rdy1;
  logic [1:0]  resp0, resp1;
  sram_state_e dbg0, dbg1;

  // Only one slave is ever in a data phase, and an inactive slave is ready with zero data.
  logic        hready_bus;
  logic [1:0]  hresp_bus;
  logic [31:0] hrdata_bus;
  assign hready_bus = rdy0 & rdy1;
  assign hresp_bus  = resp0 | resp1;
  assign hrdata_bus = rdata0 | rdata1;

  ahb_sram_ws #(.BASE_ADDR(BASE0), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADYIN(hready_bus), .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0),
    .dbg_state(dbg0)
  );

  ahb_sram_ws #(.BASE_ADDR(BASE1), .WAIT_STATES(3)) u_dut1 (
    .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL1), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADYIN(hready_bus), .HRDATA(rdata1), .HREADYOUT(rdy1), .HRESP(resp1),
    .dbg_state(dbg1)
  );

  // Scoreboard / reference model: window 0x00..0xFF of each slave, byte addressed.
  int checks = 0;
  int errors = 0;
  logic [7:0] ref_mem [2][256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ws_of(input int sel);
    return (sel == 1) ? 3 : 0;
  endfunction

  function automatic logic is_legal(input logic [31:0] off, input logic [2:0] size);
    int nbytes;
    if (size > 3'd2) return 1'b0;
    nbytes = 1 << size;
    return (off < 32'd2048) && ((off % nbytes) == 0);
  endfunction

  function automatic void model_write(input int sel, input logic [31:0] off,
                                      input logic [2:0] size, input logic [31:0] wd);
    for (int i = 0; i < (1 << size); i++) begin
      int a;
      a = int'(off) + i;
      ref_mem[sel][a] = wd[8*(a % 4) +: 8];
    end
  endfunction

  function automatic logic [31:0] model_read(input int sel, input logic [31:0] off);
    int b;
    b = int'(off) & ~3;
    return {ref_mem[sel][b+3], ref_mem[sel][b+2], ref_mem[sel][b+1], ref_mem[sel][b]};
  endfunction

  // Driver tasks. Each returns at #1 after a rising edge.
  task automatic addr_phase(input int sel, input logic [31:0] off, input logic wr,
                            input logic [2:0] size);
    HSEL0  = (sel == 0);
    HSEL1  = (sel == 1);
    HADDR  = ((sel == 1) ? BASE1 : BASE0) + off;
    HTRANS = 2'b10;
    HWRITE = wr;
    HSIZE  = size;
    @(posedge HCLK); #1;
  endtask

  task automatic idle(input logic keep_sel, input logic [1:0] tr, input string tag);
    HSEL0  = keep_sel;
    HSEL1  = 1'b0;
    HTRANS = tr;
    @(posedge HCLK); #1;
    check({tag, "_rdy"}, {31'd0, hready_bus}, 32'd1);
    check({tag, "_resp"}, {30'd0, hresp_bus}, 32'd0);
    check({tag, "_rdata"}, hrdata_bus, 32'd0);
  endtask

  // Runs a data phase up to (not past) its completing cycle, so the caller may place
  // the next address phase there.
  task automatic data_phase(input logic [31:0] wdata, input int exp_waits, input logic err,
                            input logic chk_rd, input logic [31:0] exp_rd, input string tag);
    int waits;
    logic [31:0] exp_resp;
    waits = 0;
    exp_resp = err ? 32'd1 : 32'd0;
    HWDATA = wdata;
    while (hready_bus !== 1'b1 && waits < 12) begin
      check({tag, "_resp_wait"}, {30'd0, hresp_bus}, exp_resp);
      @(posedge HCLK); #1;
      waits++;
    end
    check({tag, "_waits"}, waits, exp_waits);
    check({tag, "_resp"}, {30'd0, hresp_bus}, exp_resp);
    if (chk_rd) check({tag, "_rdata"}, hrdata_bus, exp_rd);
  endtask

  initial begin
    logic [31:0] wd, off;
    logic [2:0]  size;
    logic        wr;
    int          sel;

    // Reset
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_rdy0", {31'd0, rdy0}, 32'd1);
    check("rst_rdy1", {31'd0, rdy1}, 32'd1);
    check("rst_resp", {30'd0, hresp_bus}, 32'd0);
    check("rst_rdata", hrdata_bus, 32'd0);
    check("rst_state0", 32'(dbg0), 32'(ST_IDLE));
    check("rst_state1", 32'(dbg1), 32'(ST_IDLE));
    HRESETN = 1'b1;
    @(posedge HCLK); #1;

    // Prefill the model window of both slaves, back-to-back word writes.
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 64; w++) begin
        wd = $urandom;
        addr_phase(s, 32'(w * 4), 1'b1, 3'd2);
        model_write(s, 32'(w * 4), 3'd2, wd);
        data_phase(wd, ws_of(s), 1'b0, 1'b0, 32'd0, "fill");
      end
    end
    idle(1'b0, 2'b00, "idle_after_fill");

    // Zero-wait write then read-after-write.
    addr_phase(0, 32'h10, 1'b1, 3'd2);
    model_write(0, 32'h10, 3'd2, 32'hDEADBEEF);
    data_phase(32'hDEADBEEF, 0, 1'b0, 1'b0, 32'd0, "ws0_wr");
    addr_phase(0, 32'h10, 1'b0, 3'd2);
    data_phase(32'd0, 0, 1'b0, 1'b1, 32'hDEADBEEF, "ws0_rd");
    idle(1'b0, 2'b00, "idle1");

    // Three wait states, then back-to-back NONSEQ in the completing cycle.
    addr_phase(1, 32'h20, 1'b0, 3'd2);
    data_phase(32'd0, 3, 1'b0, 1'b1, model_read(1, 32'h20), "ws3_rd");
    addr_phase(1, 32'h24, 1'b0, 3'd2);
    data_phase(32'd0, 3, 1'b0, 1'b1, model_read(1, 32'h24), "ws3_b2b");
    idle(1'b0, 2'b00, "idle2");

    // Byte lanes.
    addr_phase(0, 32'h40, 1'b1, 3'd2);
    model_write(0, 32'h40, 3'd2, 32'h0);
    data_phase(32'h0, 0, 1'b0, 1'b0, 32'd0, "fill40");
    addr_phase(0, 32'h42, 1'b1, 3'd0);
    model_write(0, 32'h42, 3'd0, 32'h00AB0000);
    data_phase(32'h00AB0000, 0, 1'b0, 1'b0, 32'd0, "byte42");
    addr_phase(0, 32'h40, 1'b0, 3'd2);
    data_phase(32'd0, 0, 1'b0, 1'b1, 32'h00AB0000, "rd_byte42");
    addr_phase(0, 32'h40, 1'b1, 3'd1);
    model_write(0, 32'h40, 3'd1, 32'h00001234);
    data_phase(32'h00001234, 0, 1'b0, 1'b0, 32'd0, "half40");
    addr_phase(0, 32'h40, 1'b0, 3'd2);
    data_phase(32'd0, 0, 1'b0, 1'b1, 32'h00AB1234, "rd_half40");

    // Errors: out of range, misaligned halfword write.
    addr_phase(0, 32'h800, 1'b0, 3'd2);
    data_phase(32'd0, 1, 1'b1, 1'b1, 32'd0, "err_range");
    addr_phase(0, 32'h41, 1'b1, 3'd1);
    data_phase(32'hFFFFFFFF, 1, 1'b1, 1'b1, 32'd0, "err_misalign");
    addr_phase(0, 32'h40, 1'b0, 3'd2);
    data_phase(32'd0, 0, 1'b0, 1'b1, 32'h00AB1234, "rd_after_err");
    addr_phase(1, 32'h40, 1'b0, 3'd3);
    data_phase(32'd0, 1, 1'b1, 1'b1, 32'd0, "err_size");
    idle(1'b1, 2'b01, "busy_sel");
    idle(1'b1, 2'b00, "idle_sel");

    // Reset during the second wait cycle of a write to 0x30.
    addr_phase(1, 32'h30, 1'b1, 3'd2);
    HWDATA = 32'hCAFEF00D;
    @(posedge HCLK); #1;
    HRESETN = 1'b0;
    #1;
    check("rst_mid_rdy", {31'd0, hready_bus}, 32'd1);
    check("rst_mid_resp", {30'd0, hresp_bus}, 32'd0);
    check("rst_mid_rdata", hrdata_bus, 32'd0);
    HSEL1 = 1'b0;
    HTRANS = 2'b00;
    @(posedge HCLK); #1;
    HRESETN = 1'b1;
    @(posedge HCLK); #1;
    addr_phase(1, 32'h30, 1'b0, 3'd2);
    data_phase(32'd0, 3, 1'b0, 1'b1, model_read(1, 32'h30), "rd_30_after_rst");

    // Random transfers against the model.
    for (int n = 0; n < 80; n++) begin
      logic ok;
      sel  = int'($urandom_range(0, 1));
      size = 3'($urandom_range(0, 3));
      off  = ($urandom_range(0, 9) == 0) ? 32'h800 + 32'($urandom_range(0, 7))
                                         : 32'($urandom_range(0, 255));
      wr   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      ok   = is_legal(off, size);
      addr_phase(sel, off, wr, size);
      if (!ok) begin
        data_phase(wd, 1, 1'b1, 1'b1, 32'd0, "rnd_err");
      end else if (wr) begin
        model_write(sel, off, size, wd);
        data_phase(wd, ws_of(sel), 1'b0, 1'b0, 32'd0, "rnd_wr");
      end else begin
        data_phase(wd, ws_of(sel), 1'b0, 1'b1, model_read(sel, off), "rnd_rd");
      end
      if ($urandom_range(0, 2) == 0) idle(1'b0, 2'b00, "rnd_idle");
    end
    idle(1'b0, 2'b00, "idle_end");

`ifdef AHB_SRAM_PARITY_EN
    // Corrupt the parity of byte 0x50 lane 0 of slave 0.
    u_dut0.u_mem.par_q[20][0] = ~u_dut0.u_mem.par_q[20][0];
    addr_phase(0, 32'h50, 1'b0, 3'd0);
    data_phase(32'd0, 1, 1'b1, 1'b1, 32'd0, "par_err50");
    addr_phase(0, 32'h51, 1'b0, 3'd0);
    data_phase(32'd0, 0, 1'b0, 1'b1, model_read(0, 32'h51), "par_ok51");
    idle(1'b0, 2'b00, "idle_par");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
